mem_write_arbiter: RTL and testbench
====================================

// Module: mem_write_arbiter
// PURPOSE
//  Shares the single data-memory write port between NUM_REQ save requesters (store units, DMA, debug).
//  Each requester presents address+data and holds req until its done pulse.
//  The block grants one requester at a time and latches its address/data.
//  It drives a one-cycle memory write, then acknowledges the requester. Sits between save units and data memory.
// PARAMETERS
//  DATA_WIDTH        8   width of one memory word
//  DATA_MEMORY_SIZE  64  memory depth; AW = $clog2(DATA_MEMORY_SIZE)
//  NUM_REQ           4   number of requesters (>=2); IW = $clog2(NUM_REQ)
// PORTS
//  clk       in   1               single clock, rising edge
//  rst_n     in   1               asynchronous, active-low reset
//  req       in   NUM_REQ         req[i]=1: requester i wants a write; held until done[i]
//  req_addr  in   NUM_REQ*AW      requester i address at bits [i*AW +: AW]
//  req_data  in   NUM_REQ*DW      requester i data at bits [i*DW +: DW]
//  done      out  NUM_REQ         one-hot, 1-cycle pulse: write of requester i committed
//  mem_we    out  1               memory write enable, 1 cycle per transaction
//  mem_addr  out  AW              latched write address
//  mem_data  out  DATA_WIDTH      latched write data
//  busy      out  1               1 while in WRITE or ACK
//  grant_id  out  IW              index of current/last granted requester
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; done=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, grant_id=0, rr_ptr=0.
//   Reset mid-transaction aborts it immediately; no done pulse is issued for the aborted write.
//  FSM: IDLE -> WRITE -> ACK -> IDLE; all outputs registered.
//   IDLE: if any req bit set at posedge, arbitrate (below).
//    Latch winner's addr/data into mem_addr/mem_data and set grant_id=winner.
//    Set mem_we=1, busy=1, go WRITE. If no req is set, stay IDLE with all strobes 0.
//   WRITE: mem_we high for exactly this cycle. Next posedge: mem_we=0, done[grant_id]=1, go ACK.
//   ACK: done pulse visible for exactly this cycle.
//    Next posedge: done=0, busy=0, rr_ptr=grant_id+1 (wraps NUM_REQ-1 -> 0), go IDLE.
//  Latency: req sampled at edge N -> mem_we high N..N+1 -> done high N+1..N+2.
//   Max throughput: one write per 3 cycles.
//  Arbitration (round-robin): search indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ; first asserted req wins.
//   After reset, requester 0 has top priority.
//  Requester rules: addr/data sampled only at the IDLE->WRITE edge; later changes are ignored.
//   Dropping req during WRITE/ACK does not cancel the write; done is still pulsed.
//   Requester must deassert req on the edge where it observes done, or it re-enters arbitration.
//  Non-granted requesters keep req high and wait; no request is lost.
//  Pointer update happens only on ACK exit, never in IDLE without a grant.
//  mem_addr/mem_data hold their last value when idle; mem_we is the only qualifier.
//  grant_id is meaningful only while busy=1.
// CONFIGURATION
//  FIXED_PRIO_EN defined: rr_ptr is removed. Lowest asserted index always wins (req[0] highest).
//   Starvation of high indices is accepted.
//  FIXED_PRIO_EN undefined (default): round-robin as above.
//  FSM, latency and port list are identical in both builds.
// TESTING
//  1. Reset, req=4'b0100, addr2=6'h15, data2=8'hA5 -> mem_we 1 cycle with addr 15/data A5,
//     then done=4'b0100 next cycle; busy high 2 cycles.
//  2. req=4'b1111 held, each requester drops on its done -> grant order 0,1,2,3; 4 writes in 12 cycles.
//  3. req0 and req2 held continuously (re-raised after done) -> grants alternate 0,2,0,2.
//     With FIXED_PRIO_EN: always 0.
//  4. req1 granted, requester changes addr/data and drops req during WRITE
//     -> memory receives originally latched values; done[1] still pulses.
//  5. rst_n low during WRITE -> mem_we, busy, done drop to 0 immediately.
//     After release, state IDLE, rr_ptr=0; held req3 is granted on the first edge.
//  6. No req for 20 cycles -> mem_we=0, done=0, busy=0 throughout.

Source files
------------

// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter: shares the single data-memory write port between NUM_REQ
// requesters. A winner is chosen in IDLE and its address/data are latched; one
// WRITE cycle (mem_we) follows, then one ACK cycle (done pulse), then back to IDLE.
// All outputs are registered.
//
// Build option: define FIXED_PRIO_EN for fixed priority (lowest asserted index
// always wins, no rotating pointer). Default is round-robin.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for any req; arbitrates and latches winner
//   WRITE | mem_we high for this single cycle
//   ACK   | done[grant_id] high for this single cycle
module mem_write_arbiter #(
  parameter int DATA_WIDTH       = 8,
  parameter int DATA_MEMORY_SIZE = 64,
  parameter int NUM_REQ          = 4,
  localparam int AW = $clog2(DATA_MEMORY_SIZE),
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*AW-1:0]        req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           done,
  output logic                         mem_we,
  output logic [AW-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_data,
  output logic                         busy,
  output logic [IW-1:0]                grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]         addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  logic                  any_req;
  logic [IW-1:0]         winner;

  logic                  mem_we_nxt;
  logic                  busy_nxt;
  logic [NUM_REQ-1:0]    done_nxt;
  logic [AW-1:0]         mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_data_nxt;
  logic [IW-1:0]         grant_id_nxt;

  // Unpack the flat requester buses into per-requester views
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*AW +: AW];
      data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign any_req = |req;

`ifdef FIXED_PRIO_EN
  // Fixed priority: scan downward so the lowest asserted index is written last
  always_comb begin
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) winner = IW'(k);
    end
  end
`else
  typedef logic [IW:0] ext_t;

  logic [IW-1:0] rr_ptr, rr_ptr_nxt;

  // Round-robin: first asserted req searching upward from rr_ptr, modulo NUM_REQ
  always_comb begin
    ext_t idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ext_t'(rr_ptr) + ext_t'(k);
      if (idx >= ext_t'(NUM_REQ)) idx = idx - ext_t'(NUM_REQ);
      if (!found && req[idx[IW-1:0]]) begin
        winner = idx[IW-1:0];
        found  = 1'b1;
      end
    end
  end

  // Pointer advances past the granted requester only when leaving ACK
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (state == ACK) begin
      if (grant_id == IW'(NUM_REQ - 1)) rr_ptr_nxt = '0;
      else                              rr_ptr_nxt = grant_id + 1'b1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= '0;
    else        rr_ptr <= rr_ptr_nxt;
  end
`endif

  // State and registered-output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      mem_we   <= mem_we_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      mem_addr <= mem_addr_nxt;
      mem_data <= mem_data_nxt;
      grant_id <= grant_id_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = WRITE;
      WRITE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; address/data hold when idle
  always_comb begin
    mem_we_nxt   = 1'b0;
    busy_nxt     = 1'b0;
    done_nxt     = '0;
    mem_addr_nxt = mem_addr;
    mem_data_nxt = mem_data;
    grant_id_nxt = grant_id;
    case (state)
      IDLE: begin
        if (any_req) begin
          mem_addr_nxt = addr_arr[winner];
          mem_data_nxt = data_arr[winner];
          grant_id_nxt = winner;
          mem_we_nxt   = 1'b1;
          busy_nxt     = 1'b1;
        end
      end
      WRITE: begin
        done_nxt[grant_id] = 1'b1;
        busy_nxt           = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed self-checking bench for mem_write_arbiter (DW=8, 64 words, 4 requesters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_write_arbiter;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   done;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic            busy;
  logic [1:0]      grant_id;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_write_arbiter #(.DATA_WIDTH(DW), .DATA_MEMORY_SIZE(64), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .done(done), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[id*AW +: AW] = a;
    req_data[id*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One full transaction expected to start on the next rising edge
  task automatic txn(input string tag, input int id, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input bit reraise);
    step();
    chk({tag, "_we"},   32'(mem_we), 32'd1);
    chk({tag, "_gid"},  32'(grant_id), 32'(id));
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_data"}, 32'(mem_data), 32'(d));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done0"}, 32'(done), 32'd0);
    step();
    chk({tag, "_we_off"}, 32'(mem_we), 32'd0);
    chk({tag, "_done"},   32'(done), 32'd1 << id);
    chk({tag, "_busy2"},  32'(busy), 32'd1);
    req[id] = 1'b0;
    step();
    chk({tag, "_done_off"}, 32'(done), 32'd0);
    chk({tag, "_idle"},     32'(busy), 32'd0);
    chk({tag, "_we_idle"},  32'(mem_we), 32'd0);
    if (reraise) req[id] = 1'b1;
  endtask

  initial begin
    req      = '0;
    req_addr = '0;
    req_data = '0;
    rst_n    = 1'b0;
    step();

    // Reset values
    chk("rst_we",   32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid",  32'(grant_id), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    rst_n = 1'b1;

    // 1: single request from requester 2
    set_req(2, 6'h15, 8'hA5);
    req = 4'b0100;
    txn("t1", 2, 6'h15, 8'hA5, 1'b0);
    chk("t1_addr_hold", 32'(mem_addr), 32'h15);
    chk("t1_data_hold", 32'(mem_data), 32'hA5);

    // 2: all four request from reset -> 0,1,2,3 back to back (12 cycles)
    do_reset();
    set_req(0, 6'h01, 8'h10);
    set_req(1, 6'h02, 8'h21);
    set_req(3, 6'h3F, 8'h43);
    req = 4'b1111;
    txn("t2a", 0, 6'h01, 8'h10, 1'b0);
    txn("t2b", 1, 6'h02, 8'h21, 1'b0);
    txn("t2c", 2, 6'h15, 8'hA5, 1'b0);
    txn("t2d", 3, 6'h3F, 8'h43, 1'b0);

    // 3: requesters 0 and 2 continuously requesting
    do_reset();
    req = 4'b0101;
`ifdef FIXED_PRIO_EN
    txn("t3a", 0, 6'h01, 8'h10, 1'b1);
    txn("t3b", 0, 6'h01, 8'h10, 1'b1);
    txn("t3c", 0, 6'h01, 8'h10, 1'b1);
    txn("t3d", 0, 6'h01, 8'h10, 1'b1);
`else
    txn("t3a", 0, 6'h01, 8'h10, 1'b1);
    txn("t3b", 2, 6'h15, 8'hA5, 1'b1);
    txn("t3c", 0, 6'h01, 8'h10, 1'b1);
    txn("t3d", 2, 6'h15, 8'hA5, 1'b1);
`endif
    req = '0;
    step();
    step();

    // 4: requester 1 changes addr/data and drops req during WRITE
    set_req(1, 6'h2A, 8'h3C);
    req = 4'b0010;
    step();
    chk("t4_we",   32'(mem_we), 32'd1);
    chk("t4_gid",  32'(grant_id), 32'd1);
    chk("t4_addr", 32'(mem_addr), 32'h2A);
    chk("t4_data", 32'(mem_data), 32'h3C);
    set_req(1, 6'h11, 8'hFF);
    req = '0;
    step();
    chk("t4_done",      32'(done), 32'b0010);
    chk("t4_addr_keep", 32'(mem_addr), 32'h2A);
    chk("t4_data_keep", 32'(mem_data), 32'h3C);
    step();
    chk("t4_idle", 32'(busy), 32'd0);

    // 5: reset asserted during WRITE aborts the write
    req = 4'b0001;
    step();
    chk("t5_in_write", 32'(mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_we",   32'(mem_we), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    req = 4'b1000;
    step();
    chk("t5_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    txn("t5", 3, 6'h3F, 8'h43, 1'b0);

    // 6: idle for 20 cycles
    req = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t6_we",   32'(mem_we), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
